// File: rtl/i2s_rx_fifo.sv
// I2S receive front end: synchronised capture, MSB-first deserialiser, channel-tagged FIFO.
// Define I2S_RX_OVERWRITE_EN to discard the oldest word on overflow instead of the newest.
module i2s_rx_fifo #(
  parameter int DATA_W      = 24,
  parameter int DEPTH       = 64,
  parameter int THRESH      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     sck,
  input  logic                     ws,
  input  logic                     sd,
  input  logic                     rd_req,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_ch,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     irq,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_W + 1);

`ifdef I2S_RX_OVERWRITE_EN
  localparam logic OVERWRITE = 1'b1;
`else
  localparam logic OVERWRITE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_t;

  // Synchronisers for sck (0), ws (1) and sd (2)
  logic [2:0] async_in;
  logic [2:0] sync_out;
  assign async_in = {sd, ws, sck};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] stages_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stages_reg <= '0;
        else        stages_reg <= {stages_reg[SYNC_STAGES-2:0], async_in[gi]};
      end
      assign sync_out[gi] = stages_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic sck_s, ws_s, sd_s;
  assign sck_s = sync_out[0];
  assign ws_s  = sync_out[1];
  assign sd_s  = sync_out[2];

  state_t            state_reg, state_next;
  logic              ch_reg, ch_next;
  logic [CW-1:0]     cnt_reg, cnt_next, cnt_inc;
  logic [DATA_W-1:0] shreg_reg, shreg_next, shreg_cap;
  logic              ws_prev_reg, sck_d_reg;
  logic              rise, ws_change, push;

  assign rise      = sck_s & ~sck_d_reg;
  assign ws_change = rise & (ws_s ^ ws_prev_reg);
  assign shreg_cap = {shreg_reg[DATA_W-2:0], sd_s};
  assign cnt_inc   = cnt_reg + CW'(1);

  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    cnt_next   = cnt_reg;
    shreg_next = shreg_reg;
    push       = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else if (rise) begin
      case (state_reg)
        IDLE: begin
          if (ws_change) begin
            ch_next    = ws_s;
            cnt_next   = '0;
            state_next = SHIFT;
          end
        end
        SHIFT: begin
          shreg_next = shreg_cap;
          cnt_next   = cnt_inc;
          if (cnt_inc == CW'(DATA_W)) begin
            push       = 1'b1;
            state_next = WAIT;
          end
          // A ws change after the capture either follows a completed word or drops a partial one
          if (ws_change) begin
            ch_next    = ws_s;
            cnt_next   = '0;
            state_next = SHIFT;
          end
        end
        WAIT: begin
          if (ws_change) begin
            ch_next    = ws_s;
            cnt_next   = '0;
            state_next = SHIFT;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ch_reg      <= 1'b0;
      cnt_reg     <= '0;
      shreg_reg   <= '0;
      ws_prev_reg <= 1'b0;
      sck_d_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
      cnt_reg   <= cnt_next;
      shreg_reg <= shreg_next;
      sck_d_reg <= sck_s;
      if (rise) ws_prev_reg <= ws_s;
    end
  end

  // FIFO
  logic [DATA_W:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic              overflow_reg, rd_valid_reg, rd_ch_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic              do_pop, full, wr_en, ovf_set, rd_adv;

  assign do_pop  = rd_req & (level_reg != '0);
  assign full    = (level_reg == LW'(DEPTH));
  assign wr_en   = push & (~full | do_pop | OVERWRITE);
  assign ovf_set = push & full & ~do_pop;
  assign rd_adv  = do_pop | (ovf_set & OVERWRITE);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {ch_reg, shreg_cap};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_ch_reg    <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      rd_valid_reg <= do_pop;
      if (do_pop) {rd_ch_reg, rd_data_reg} <= mem[rd_ptr_reg];
      if (wr_en)  wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_adv) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_reg + LW'(wr_en) - LW'(rd_adv);
      if (ovf_set)      overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_ch    = rd_ch_reg;
  assign rd_valid = rd_valid_reg;
  assign level    = level_reg;
  assign overflow = overflow_reg;
  assign irq      = (level_reg >= LW'(THRESH));

endmodule
